// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-word pipeline: stage indices, control-word
// field positions and the per-stage update priority.
package ctrl_pipe_pkg;

  localparam int unsigned W_DEFAULT = 16;

  localparam int unsigned STG_D = 0;
  localparam int unsigned STG_E = 1;
  localparam int unsigned STG_M = 2;
  localparam int unsigned STG_W = 3;

  localparam int unsigned BR_BIT       = 0;
  localparam int unsigned JUMP_BIT     = 1;
  localparam int unsigned REGWRITE_BIT = 2;
  localparam int unsigned MEMWRITE_BIT = 3;
  localparam int unsigned MEMTOREG_BIT = 4;
  localparam int unsigned ALUCTRL_LSB  = 5;
  localparam int unsigned ALUCTRL_MSB  = 7;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_HOLD   = 2'd1,
    OP_BUBBLE = 2'd2,
    OP_KILL   = 2'd3
  } stage_op_e;

  // Kill beats stall beats bubble beats load.
  function automatic stage_op_e stage_op(input logic kill, input logic stall,
                                         input logic bubble);
    if (kill)        return OP_KILL;
    else if (stall)  return OP_HOLD;
    else if (bubble) return OP_BUBBLE;
    else             return OP_LOAD;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: valid bit plus control word, updated with
// kill > stall > bubble > load priority. Invalid words are always stored as 0.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_kill,
  input  logic         i_stall,
  input  logic         i_bubble,
  input  logic         i_valid,
  input  logic [W-1:0] i_word,
  output logic         o_valid,
  output logic [W-1:0] o_word
);

  logic         r_valid;
  logic [W-1:0] r_word;
  stage_op_e    w_op;
  logic         w_valid_nxt;
  logic [W-1:0] w_word_nxt;

  always_comb begin
    w_op        = stage_op(i_kill, i_stall, i_bubble);
    w_valid_nxt = r_valid;
    w_word_nxt  = r_word;
    case (w_op)
      OP_KILL, OP_BUBBLE: begin
        w_valid_nxt = 1'b0;
        w_word_nxt  = '0;
      end
      OP_HOLD: begin
        w_valid_nxt = r_valid;
        w_word_nxt  = r_word;
      end
      default: begin
        w_valid_nxt = i_valid;
        w_word_nxt  = i_valid ? i_word : '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_word  <= w_word_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from decode through STAGES register stages with
// per-stage stall/flush, automatic bubbles and branch redirect at RES_STAGE.
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned W         = W_DEFAULT,
  parameter int unsigned STAGES    = 3,
  parameter int unsigned RES_STAGE = STG_M,
  parameter int unsigned BR_BIT    = ctrl_pipe_pkg::BR_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          word_d_i,
  input  logic                  valid_d_i,
  input  logic [STAGES:0]       stall_i,
  input  logic [STAGES:0]       flush_i,
  input  logic                  branchok_i,
  output logic [STAGES*W-1:0]   word_o,
  output logic [STAGES-1:0]     valid_o,
  output logic                  pcsrc_o,
  output logic [STAGES:0]       kill_o
);

  // Index 0 is the decode input; 1..STAGES are the registered stages.
  logic [STAGES:0]        w_valid;
  logic [STAGES:0][W-1:0] w_word;
  logic [STAGES:0]        w_kill;
  logic                   w_pcsrc;

  assign w_valid[0] = valid_d_i;
  assign w_word[0]  = word_d_i;

  assign w_pcsrc = w_valid[RES_STAGE] & w_word[RES_STAGE][BR_BIT] & branchok_i;

  // A redirect kills decode and every stage younger than the resolving stage.
  always_comb begin
    w_kill = '0;
    for (int unsigned k = 0; k <= STAGES; k++) begin
      w_kill[k] = flush_i[k] | (w_pcsrc & (k < RES_STAGE));
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    ctrl_stage_reg #(
      .W (W)
    ) u_stage (
      .clk      (clk),
      .i_rst_n  (rst),
      .i_kill   (w_kill[k]),
      .i_stall  (stall_i[k]),
      .i_bubble (stall_i[k-1] | w_kill[k-1]),
      .i_valid  (w_valid[k-1]),
      .i_word   (w_word[k-1]),
      .o_valid  (w_valid[k]),
      .o_word   (w_word[k])
    );
    assign word_o[k*W-1 -: W] = w_word[k];
  end

  assign valid_o = w_valid[STAGES:1];
  assign pcsrc_o = w_pcsrc;
  assign kill_o  = w_kill;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain: directed scenarios plus random
// traffic compared against an instruction-slot reference model.
module tb_ctrl_pipe_chain;

  localparam int S   = 3;
  localparam int WW  = 16;
  localparam int RS  = 2;
  localparam int BRB = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic [WW-1:0]     word_d_i;
  logic              valid_d_i;
  logic [S:0]        stall_i;
  logic [S:0]        flush_i;
  logic              branchok_i;
  logic [S*WW-1:0]   word_o;
  logic [S-1:0]      valid_o;
  logic              pcsrc_o;
  logic [S:0]        kill_o;

  int n_cmp = 0;
  int n_mis = 0;

  logic          m_v [0:S];
  logic [WW-1:0] m_w [0:S];

  ctrl_pipe_chain #(
    .W         (WW),
    .STAGES    (S),
    .RES_STAGE (RS),
    .BR_BIT    (BRB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_d_i   (word_d_i),
    .valid_d_i  (valid_d_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .branchok_i (branchok_i),
    .word_o     (word_o),
    .valid_o    (valid_o),
    .pcsrc_o    (pcsrc_o),
    .kill_o     (kill_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_pc();
    return m_v[RS] && m_w[RS][BRB] && branchok_i;
  endfunction

  function automatic logic [S:0] model_kill(input logic pc);
    logic [S:0] kl;
    for (int k = 0; k <= S; k++) kl[k] = flush_i[k] | (pc && (k < RS));
    return kl;
  endfunction

  task automatic model_clear();
    for (int k = 0; k <= S; k++) begin
      m_v[k] = 1'b0;
      m_w[k] = '0;
    end
  endtask

  task automatic model_check();
    logic pc;
    pc = model_pc();
    check("pcsrc", 64'(pcsrc_o), 64'(pc));
    check("kill", 64'(kill_o), 64'(model_kill(pc)));
    check("valid", 64'(valid_o), 64'({m_v[3], m_v[2], m_v[1]}));
    check("word", 64'(word_o), 64'({m_w[3], m_w[2], m_w[1]}));
  endtask

  // Apply inputs mid-cycle, then compare everything against the model.
  task automatic drive(input logic [WW-1:0] w, input logic v, input logic [S:0] st,
                       input logic [S:0] fl, input logic bok);
    @(negedge clk);
    word_d_i   = w;
    valid_d_i  = v;
    stall_i    = st;
    flush_i    = fl;
    branchok_i = bok;
    #1;
    model_check();
  endtask

  // Advance the model by one clock: each slot is killed, held, emptied or
  // takes the instruction from the slot behind it.
  task automatic tick();
    logic          pc;
    logic [S:0]    kl;
    logic          nv [0:S];
    logic [WW-1:0] nw [0:S];
    @(posedge clk);
    pc = model_pc();
    kl = model_kill(pc);
    for (int k = 1; k <= S; k++)
      if (stall_i[k] && !stall_i[k-1]) $display("NOTE illegal stall pattern %b", stall_i);
    for (int k = 1; k <= S; k++) begin
      if (kl[k]) begin
        nv[k] = 1'b0; nw[k] = '0;
      end else if (stall_i[k]) begin
        nv[k] = m_v[k]; nw[k] = m_w[k];
      end else if (stall_i[k-1] || kl[k-1]) begin
        nv[k] = 1'b0; nw[k] = '0;
      end else if (k == 1) begin
        nv[k] = valid_d_i; nw[k] = valid_d_i ? word_d_i : '0;
      end else begin
        nv[k] = m_v[k-1]; nw[k] = m_w[k-1];
      end
    end
    for (int k = 1; k <= S; k++) begin
      m_v[k] = nv[k];
      m_w[k] = nw[k];
    end
    #1;
  endtask

  initial begin
    logic [S:0] st;
    logic [S:0] fl;
    int         d;

    model_clear();
    rst        = 1'b0;
    word_d_i   = 16'hFFFF;
    valid_d_i  = 1'b1;
    stall_i    = '0;
    flush_i    = 4'b0101;
    branchok_i = 1'b1;

    // Reset held across edges with live decode input
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_word", 64'(word_o), 64'h0);
    check("rst_pcsrc", 64'(pcsrc_o), 64'h0);
    check("rst_kill", 64'(kill_o), 64'h5);
    flush_i = '0;
    rst     = 1'b1;
    #1;
    check("rel_valid", 64'(valid_o), 64'h0);
    check("rel_word", 64'(word_o), 64'h0);
    tick();
    check("rel_s1", 64'(word_o[15:0]), 64'hFFFF);
    check("rel_v", 64'(valid_o), 64'h1);

    // Streaming
    drive(16'h0001, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    drive(16'h0002, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    drive(16'h0003, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    check("str_s3", 64'(word_o[47:32]), 64'h1);
    check("str_v", 64'(valid_o), 64'h7);
    drive(16'h0004, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    check("str_s3b", 64'(word_o[47:32]), 64'h2);
    check("str_vb", 64'(valid_o), 64'h7);

    // Stall with bubble
    drive(16'h0042, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    drive(16'h0099, 1'b1, 4'b0011, 4'b0000, 1'b0); tick();
    check("stl_s3", 64'(word_o[47:32]), 64'h4);
    drive(16'h0099, 1'b1, 4'b0011, 4'b0000, 1'b0); tick();
    check("stl_s1", 64'(word_o[15:0]), 64'h42);
    check("stl_s2w", 64'(word_o[31:16]), 64'h0);
    check("stl_v", 64'(valid_o), 64'h1);

    // Flush over stall
    drive(16'h0077, 1'b1, 4'b0011, 4'b0010, 1'b0); tick();
    check("fos_v1", 64'(valid_o[0]), 64'h0);
    check("fos_s1", 64'(word_o[15:0]), 64'h0);

    // Taken branch resolving in stage 2
    drive(16'h0081, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    drive(16'h0010, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    drive(16'h0020, 1'b1, 4'b0000, 4'b0000, 1'b1);
    check("br_pcsrc", 64'(pcsrc_o), 64'h1);
    check("br_kill", 64'(kill_o), 64'h3);
    tick();
    check("br_s3", 64'(word_o[47:32]), 64'h81);
    check("br_v", 64'(valid_o), 64'h4);
    check("br_s12", 64'(word_o[31:0]), 64'h0);

    // Taken branch with stages 0..2 stalled
    drive(16'h0081, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    drive(16'h0030, 1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(16'h0040, 1'b1, 4'b0111, 4'b0000, 1'b1);
      check("brs_pcsrc", 64'(pcsrc_o), 64'h1);
      check("brs_kill", 64'(kill_o), 64'h3);
      tick();
      check("brs_s2", 64'(word_o[31:16]), 64'h81);
      check("brs_v", 64'(valid_o[1:0]), 64'h2);
    end

    // Random traffic with legal (thermometer) stall patterns
    for (int i = 0; i < 400; i++) begin
      st = '0;
      fl = '0;
      if ($urandom_range(0, 3) == 0) begin
        d  = int'($urandom_range(1, S + 1));
        st = (S+1)'((5'd1 << d) - 5'd1);
      end
      if ($urandom_range(0, 7) == 0) fl = (S+1)'($urandom);
      drive(16'($urandom), 1'($urandom), st, fl, 1'($urandom));
      tick();
      if (i == 200) begin
        // Asynchronous reset asserted between edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(valid_o), 64'h0);
        check("arst_word", 64'(word_o), 64'h0);
        check("arst_pcsrc", 64'(pcsrc_o), 64'h0);
        model_clear();
        word_d_i   = '0;
        valid_d_i  = 1'b0;
        stall_i    = '0;
        flush_i    = '0;
        branchok_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised control-word pipeline that replaces the hand-wired per-stage control flops in the CPU controller. It carries a W-bit control word plus a valid bit from decode through STAGES register stages (E, M, W by default). Each stage has independent stall and flush, and the chain inserts bubbles automatically. At a configurable stage it resolves taken branches and kills all younger stages.

## Interface
- W, default 16: control word width (memtoreg, memwrite, regwrite, alucontrol, branch, jump, …).
- STAGES, default 3: number of register stages after decode; legal range 2..6.
- RES_STAGE, default 2: stage index (1..STAGES) where branches resolve; 2 = M.
- BR_BIT, default 0: bit of the control word that marks a conditional branch.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- word_d_i  in  W  decoded control word of the instruction in decode.
- valid_d_i  in  1  decode holds a real instruction.
- stall_i  in  STAGES+1  bit 0 = decode stall, bit k = stage k hold.
- flush_i  in  STAGES+1  bit 0 = decode flush, bit k = clear stage k.
- branchok_i  in  1  branch condition true for the instruction in RES_STAGE.
- word_o  out  STAGES*W  stage k word at bits [k*W-1 : (k-1)*W].
- valid_o  out  STAGES  valid bit per stage.
- pcsrc_o  out  1  taken branch in RES_STAGE; redirect the PC.
- kill_o  out  STAGES+1  effective flush applied per stage this cycle, bit 0 = decode.

## Operation
- **Stage state.** Stage k holds {valid[k], word[k]}. Stage 0 is the combinational decode input.
- **Branch redirect.** pcsrc_o = valid[RES_STAGE] & word[RES_STAGE][BR_BIT] & branchok_i. It is combinational from registered state.
- **Effective kill.**
  - kill[k] = flush_i[k] | (pcsrc_o & k < RES_STAGE), for k = 0..STAGES.
  - A redirect kills decode and every stage younger than RES_STAGE. It never kills RES_STAGE itself or anything older.
  - kill_o = kill.
- **Next state of stage k, in priority order:**
  1. kill[k]: valid = 0, word = 0.
  2. stall_i[k]: hold.
  3. stall_i[k-1] or kill[k-1]: bubble (valid = 0, word = 0).
  4. Otherwise load from stage k-1. For k = 1 the source is {valid_d_i, word_d_i}.
- **Word gating.** A word with valid = 0 always reads 0, so downstream regwrite/memwrite bits are inert without extra gating.
- **Stall consistency is the caller's job.** If stall_i[k] is high, the hazard unit must also assert stall_i[j] for every j < k. The block does not check or repair this.
  - Stage k stalled with stage k-1 not stalled: the stage k-1 contents are overwritten and lost. The bench flags this as an illegal stimulus; the RTL takes no special action.

## Timing
- **Reset.** While rst = 0, all valid = 0 and all words = 0, so word_o = 0 and valid_o = 0. pcsrc_o = 0 and kill_o follows flush_i only.
- **Reset release.** Takes effect at the next rising edge with no additional synchronisation stage.
- **Latency.** Decode to stage k is k cycles with no stalls.
- **Same-cycle effects.** A flush or redirect in cycle n clears the stage at edge n+1. pcsrc_o and kill_o are valid in cycle n, the same cycle branchok_i is presented.
- **Stall and flush together on one stage.** Flush wins; the stage is cleared.
- **Redirect while RES_STAGE is stalled.** pcsrc_o stays high for every stalled cycle. Younger stages stay killed. The PC unit must tolerate a repeated redirect.
- **Redirect with a stalled younger stage.** Still killed, because kill has priority over stall.
- **Async reset mid-operation.** Clears state immediately without waiting for an edge. No partial-update state exists.

## Structure
- Package `ctrl_pipe_pkg`:
  - Stage index constants: STG_D = 0, STG_E = 1, STG_M = 2, STG_W = 3.
  - Control-word field bit positions: BR_BIT, JUMP_BIT, REGWRITE_BIT, MEMWRITE_BIT, MEMTOREG_BIT, ALUCTRL_LSB/MSB.
  - Default W.
- One sub-module, `ctrl_stage_reg`:
  - A single valid + W-bit register with the kill > stall > bubble > load priority.
  - Instantiated STAGES times in a generate loop.
  - Branch resolution and kill vector logic live in the top module.

## Test plan
1. **Reset.** Hold rst = 0 with word_d_i = 16'hFFFF and valid_d_i = 1, then release. Required: all valid_o = 0 and word_o = 0 until the first edge after release.
2. **Streaming.** Feed words 1, 2, 3, 4 on consecutive cycles with no stall or flush. Required: word 1 appears in stage 3 at cycle 3; valid_o = 3'b111 from cycle 3 onward.
3. **Stall with bubble.** Hold stall_i = 4'b0011 for 2 cycles while stage 1 holds 16'h0042. Required: stage 1 stays 16'h0042; stage 2 receives two bubbles (valid = 0, word = 0); stage 3 drains normally.
4. **Flush over stall.** Assert flush_i[1] = 1 and stall_i[1] = 1 in the same cycle. Required: stage 1 is cleared at the next edge.
5. **Taken branch.** Stage 2 holds a valid word with bit 0 = 1 and branchok_i = 1. Required:
   - pcsrc_o = 1 in the same cycle.
   - kill_o = 4'b0011.
   - Stages 0 and 1 are cleared at the next edge.
   - Stage 2 moves to stage 3 intact.
6. **Branch while stalled.** Same as scenario 5 but with stall_i = 4'b0111 for 3 cycles. Required: pcsrc_o = 1 for all 3 cycles; stage 1 stays cleared; stage 2 holds its word.
